// File: rtl/serial_full_adder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | serial_full_adder : bit-serial WIDTH-bit adder, LSB first, start/busy/done   |
// | Revision: 1.0                                                                |
// +----------------------------------------------------------------------------+

module serial_half_adder (
  input  logic x,
  input  logic y,
  output logic s,
  output logic c
);
  assign s = x ^ y;
  assign c = x & y;
endmodule

module serial_fa_cell (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);
  logic w_s0;
  logic w_c0;
  logic w_c1;

  serial_half_adder u_ha0 (
    .x (x),
    .y (y),
    .s (w_s0),
    .c (w_c0)
  );

  serial_half_adder u_ha1 (
    .x (w_s0),
    .y (ci),
    .s (s),
    .c (w_c1)
  );

  assign co = w_c0 | w_c1;
endmodule

module serial_full_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int CW = $clog2(WIDTH);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  localparam logic [CW-1:0] C_LAST   = CW'(WIDTH - 1);
  localparam logic [CW-1:0] C_MSB_IN = CW'(WIDTH - 2);
  localparam logic [CW-1:0] C_ONE    = CW'(1);

  logic [0:0]       r_state;
  logic [0:0]       w_state_next;
  logic             w_busy;
  logic             w_accept;
  logic             w_last;
  logic             w_capture_msb;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  // Holds the WIDTH-1 most recent sum bits; the final bit joins them on the last edge.
  logic [WIDTH-2:0] r_res;
  logic             r_c_msb;

  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;
  logic             r_done;

  logic             w_s;
  logic             w_c;
  logic [WIDTH-1:0] w_res_next;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (start)  w_state_next = S_RUN;
      S_RUN:   if (w_last) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // State-decoded controls
  always_comb begin
    w_busy   = 1'b0;
    w_accept = 1'b0;
    w_last   = 1'b0;
    case (r_state)
      S_IDLE:  w_accept = start;
      S_RUN: begin
        w_busy = 1'b1;
        w_last = (r_cnt == C_LAST);
      end
      default: w_busy = 1'b0;
    endcase
  end

  assign w_capture_msb = w_busy && (r_cnt == C_MSB_IN);

  serial_fa_cell u_fa (
    .x  (r_a[0]),
    .y  (r_b[0]),
    .ci (r_carry),
    .s  (w_s),
    .co (w_c)
  );

  assign w_res_next = {w_s, r_res};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_res   <= '0;
      r_c_msb <= 1'b0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_a     <= a;
        r_b     <= b;
        r_carry <= cin;
        r_cnt   <= '0;
        r_res   <= '0;
      end else if (w_busy) begin
        r_a     <= r_a >> 1;
        r_b     <= r_b >> 1;
        r_carry <= w_c;
        r_cnt   <= r_cnt + C_ONE;
        r_res   <= w_res_next[WIDTH-1:1];
        if (w_capture_msb) begin
          r_c_msb <= w_c;
        end
        if (w_last) begin
          r_sum  <= w_res_next;
          r_cout <= w_c;
          r_ovf  <= w_c ^ r_c_msb;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign busy = w_busy;
  assign done = r_done;
  assign sum  = r_sum;
  assign cout = r_cout;
  assign ovf  = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_serial_full_adder.sv
`default_nettype none
// Directed self-checking bench for serial_full_adder (WIDTH=8).
module tb_serial_full_adder;
  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       cin;
  logic       busy;
  logic       done;
  logic [7:0] sum;
  logic       cout;
  logic       ovf;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] held_sum;
  logic       held_cout;
  logic       held_ovf;

  serial_full_adder #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  // One start pulse, 8 RUN cycles, done cycle, one idle cycle after.
  task automatic do_op(input logic [7:0] ta, input logic [7:0] tb, input logic tcin,
                       input logic [7:0] es, input logic ec, input logic eo,
                       input bit disturb, input string tag);
    @(negedge clk);
    start = 1'b1; a = ta; b = tb; cin = tcin;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk1({tag, " busy"}, busy, 1'b1);
      chk1({tag, " done_run"}, done, 1'b0);
      chk8({tag, " sum_hold"}, sum, held_sum);
      start = 1'b0;
      if (disturb && i < 7) begin
        start = (i == 2 || i == 3);
        a     = (i == 2) ? 8'hAA : ~a;
        b     = (i == 2) ? 8'h55 : ~b;
        cin   = ~cin;
      end
    end
    @(negedge clk);
    chk1({tag, " done"}, done, 1'b1);
    chk1({tag, " busy_done"}, busy, 1'b0);
    chk8({tag, " sum"}, sum, es);
    chk1({tag, " cout"}, cout, ec);
    chk1({tag, " ovf"}, ovf, eo);
    held_sum = es; held_cout = ec; held_ovf = eo;
    @(negedge clk);
    chk1({tag, " done_clr"}, done, 1'b0);
    chk1({tag, " busy_after"}, busy, 1'b0);
    chk8({tag, " sum_keep"}, sum, es);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    held_sum = '0; held_cout = 1'b0; held_ovf = 1'b0;
    repeat (2) @(negedge clk);
    chk1("rst busy", busy, 1'b0);
    chk1("rst done", done, 1'b0);
    chk8("rst sum", sum, 8'h00);
    chk1("rst cout", cout, 1'b0);
    chk1("rst ovf", ovf, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    chk1("idle busy", busy, 1'b0);

    do_op(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1, 1'b0, "5A+3C");
    do_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, "FF+01");
    do_op(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0, "FF+FF+1");
    do_op(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, "80+80");
    do_op(8'h7F, 8'h00, 1'b1, 8'h80, 1'b0, 1'b1, 1'b0, "7F+00+1");
    do_op(8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0, 1'b1, "ignore");
    @(negedge clk);
    chk1("ignore no_restart", busy, 1'b0);
    chk1("ignore single_done", done, 1'b0);

    // Back-to-back: start stays high through the done cycle.
    @(negedge clk);
    start = 1'b1; a = 8'h01; b = 8'h02; cin = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk1("b2b busy1", busy, 1'b1);
      chk1("b2b done1_run", done, 1'b0);
    end
    @(negedge clk);
    chk1("b2b done1", done, 1'b1);
    chk1("b2b busy_gap1", busy, 1'b0);
    chk8("b2b sum1", sum, 8'h03);
    a = 8'h03; b = 8'h04;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk1("b2b busy2", busy, 1'b1);
      chk1("b2b done2_run", done, 1'b0);
      chk8("b2b sum1_hold", sum, 8'h03);
    end
    @(negedge clk);
    chk1("b2b done2", done, 1'b1);
    chk1("b2b busy_gap2", busy, 1'b0);
    chk8("b2b sum2", sum, 8'h07);
    chk1("b2b cout2", cout, 1'b0);
    chk1("b2b ovf2", ovf, 1'b0);
    start = 1'b0;
    @(negedge clk);
    chk1("b2b end done", done, 1'b0);
    chk1("b2b end busy", busy, 1'b0);

    // Abort with reset after the 4th RUN edge.
    start = 1'b1; a = 8'h5A; b = 8'h3C; cin = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk1("abort pre busy", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk1("abort busy", busy, 1'b0);
    chk1("abort done", done, 1'b0);
    chk8("abort sum", sum, 8'h00);
    chk1("abort cout", cout, 1'b0);
    chk1("abort ovf", ovf, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    held_sum = '0; held_cout = 1'b0; held_ovf = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk1("post_rst done", done, 1'b0);
      chk1("post_rst busy", busy, 1'b0);
    end
    do_op(8'h11, 8'h22, 1'b0, 8'h33, 1'b0, 1'b0, 1'b0, "11+22");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/serial_full_adder.md
Name: serial_full_adder

Overview:
Bit-serial adder. It is the addition counterpart to the team's half/full-subtractor cells.
- Adds two WIDTH-bit operands plus carry-in, LSB first, one bit per clock.
- Per-bit datapath: one full adder built from two half adders and an OR gate, plus a registered carry.
- Sits beside the subtractor blocks as the area-cheap arithmetic unit for multi-cycle datapaths. Uses a start/busy/done handshake.

Parameters:
WIDTH, 8, operand and sum width in bits (legal: 2..32)

Ports:
clk    input   1      rising-edge clock, the single clock of the block
rst_n  input   1      asynchronous active-low reset
start  input   1      request; sampled only while busy=0
a      input   WIDTH  operand A, captured on accepted start
b      input   WIDTH  operand B, captured on accepted start
cin    input   1      carry-in, captured on accepted start
busy   output  1      1 while an addition is in progress
done   output  1      one-cycle pulse: sum/cout/ovf are valid
sum    output  WIDTH  registered result a+b+cin mod 2^WIDTH
cout   output  1      carry out of the MSB
ovf    output  1      signed overflow (carry into MSB XOR carry out of MSB)

Behaviour:
- Reset (rst_n=0, asynchronous, takes effect immediately):
  - busy=0, done=0, sum=0, cout=0, ovf=0.
  - Internal shift registers, carry flop and bit counter are cleared.
  - State returns to IDLE.
- State machine has two states, IDLE and RUN.
- IDLE:
  - busy=0.
  - When start=1 at a rising edge: load a and b into shift registers, carry flop <= cin, counter <= 0, go to RUN, busy=1.
  - start=0 keeps IDLE with outputs unchanged.
- RUN, at each rising edge:
  - Compute s = a_lsb ^ b_lsb ^ carry and c = (a_lsb & b_lsb) | (carry & (a_lsb ^ b_lsb)).
  - Shift s into the result register from the MSB side.
  - Shift a and b right by one; carry <= c; counter += 1.
  - On the edge processing bit WIDTH-2, capture carry-out c as the carry into the MSB (used for ovf).
- Completion, on the edge processing bit WIDTH-1 (the WIDTH-th RUN edge):
  - sum <= final shifted result; cout <= c; ovf <= c XOR stored carry-into-MSB.
  - done <= 1; busy <= 0; state <= IDLE.
- Latency: start accepted at edge k gives done=1 and valid results in the cycle after edge k+WIDTH. Throughput is one operation per WIDTH+1 cycles.
- done is high for exactly one cycle and is cleared on the next edge unless another completion occurs.
- sum, cout and ovf hold their values until the next completion or reset. They do not change during RUN.
- start while busy=1 is ignored: no restart, and operands are not re-captured.
- start=1 in the done cycle (busy=0) is accepted: back-to-back operation with no idle gap.
- a, b and cin may change freely after capture with no effect on the current operation.
- rst_n asserted mid-RUN aborts the operation: no done pulse, all outputs return to reset values. After release the block waits in IDLE for a new start.

Test Plan:
- Reset, then WIDTH=8, a=0x5A, b=0x3C, cin=0, start for 1 cycle -> busy=1 for 8 cycles; done pulses after the 8th RUN edge; sum=0x96, cout=0, ovf=1.
- a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, ovf=0. Then a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1, ovf=0.
- a=0x80, b=0x80, cin=0 -> sum=0x00, cout=1, ovf=1. Then a=0x7F, b=0x00, cin=1 -> sum=0x80, cout=0, ovf=1.
- During RUN of a 0x10+0x20 operation, pulse start with a=0xAA, b=0x55 and toggle the a/b inputs -> ignored; result sum=0x30, exactly one done pulse.
- start held high continuously with operands 0x01+0x02, then 0x03+0x04 -> done pulses 9 cycles apart; sum=0x03 then 0x07; busy low only in done cycles.
- Assert rst_n=0 after the 4th RUN edge of 0x5A+0x3C -> outputs 0 immediately, no done. Release and start 0x11+0x22 -> sum=0x33 after 8 RUN edges.
